ui_grid_drawer: RTL

- Parametrised successor to the single-crosshair UI line drawer for the 160x120 VGA adapter path.
- Draws a configurable grid: H_COUNT full-width horizontal lines, then V_COUNT full-height vertical lines, one pixel per clock.
- Controlled by a start/busy/done handshake; drives x/y/colour/plot straight into the VGA adapter write port.
- Terminates cleanly: no unbounded sweep.

---
 rtl/ui_pkg.sv | 18 +
 rtl/ui_axis_sweep.sv | 36 +++
 rtl/ui_grid_drawer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ui_pkg.sv
// Shared types and constants for the UI grid drawer.
// Screen defaults match the 160x120 VGA adapter path.
package ui_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HLINE,
        S_VLINE,
        S_DONE
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COL_W_DEF    = 3;
    localparam int BLACK        = 0;

endpackage

// File: rtl/ui_axis_sweep.sv
// Saturating 0..LEN-1 counter with synchronous load-to-zero.
// nxt_o exposes the value the counter takes at the coming edge.
module ui_axis_sweep #(
    parameter int LEN = 160,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic         en_i,
    output logic [W-1:0] nxt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == W'(LEN - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !last_o)
            cnt_d = cnt_q + 1'b1;
    end

    assign nxt_o = cnt_d;

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ui_grid_drawer.sv
// Grid drawer: H_COUNT rows then V_COUNT columns, one pixel per clock.
// Define UI_GRID_CLEAR_EN to blank the whole screen before the grid.
module ui_grid_drawer
    import ui_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int H_COUNT  = 1,
    parameter int H_START  = 30,
    parameter int H_STEP   = 20,
    parameter int V_COUNT  = 1,
    parameter int V_START  = 80,
    parameter int V_STEP   = 40,
    parameter int COL_W    = COL_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [COL_W-1:0] colour_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [COL_W-1:0] colour_out,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam int H_N  = (H_COUNT > 0) ? H_COUNT : 1;
    localparam int V_N  = (V_COUNT > 0) ? V_COUNT : 1;
    localparam int HL_W = (H_N > 1) ? $clog2(H_N) : 1;
    localparam int VL_W = (V_N > 1) ? $clog2(V_N) : 1;

    localparam state_t AFTER_H = (V_COUNT > 0) ? S_VLINE : S_DONE;
    localparam state_t AFTER_C = (H_COUNT > 0) ? S_HLINE : AFTER_H;
`ifdef UI_GRID_CLEAR_EN
    localparam state_t FIRST = S_CLEAR;
`else
    localparam state_t FIRST = AFTER_C;
`endif

    if (H_COUNT > 0 && H_START + (H_COUNT - 1) * H_STEP >= SCREEN_H) begin : g_chk_h
        $error("horizontal line falls outside the screen");
    end
    if (V_COUNT > 0 && V_START + (V_COUNT - 1) * V_STEP >= SCREEN_W) begin : g_chk_v
        $error("vertical line falls outside the screen");
    end
    if (SCREEN_W > 2 ** X_W || SCREEN_H > 2 ** Y_W) begin : g_chk_w
        $error("screen size exceeds coordinate width");
    end

    // Line positions are elaboration constants indexed by the line counter.
    logic [Y_W-1:0] hrow [2**HL_W];
    logic [X_W-1:0] vcol [2**VL_W];

    for (genvar g = 0; g < 2 ** HL_W; g++) begin : g_hrow
        assign hrow[g] = (g < H_COUNT) ? Y_W'(H_START + g * H_STEP) : '0;
    end
    for (genvar g = 0; g < 2 ** VL_W; g++) begin : g_vcol
        assign vcol[g] = (g < V_COUNT) ? X_W'(V_START + g * V_STEP) : '0;
    end

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] c_q, c_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic            xs_ld, xs_en, xs_last;
    logic            ys_ld, ys_en, ys_last;
    logic            hl_ld, hl_en, hl_last;
    logic            vl_ld, vl_en, vl_last;
    logic [X_W-1:0]  xs_nxt;
    logic [Y_W-1:0]  ys_nxt;
    logic [HL_W-1:0] hl_nxt;
    logic [VL_W-1:0] vl_nxt;

    ui_axis_sweep #(.LEN(SCREEN_W), .W(X_W)) u_xs (
        .clk(clk), .resetn(resetn), .load_i(xs_ld), .en_i(xs_en),
        .nxt_o(xs_nxt), .last_o(xs_last)
    );
    ui_axis_sweep #(.LEN(SCREEN_H), .W(Y_W)) u_ys (
        .clk(clk), .resetn(resetn), .load_i(ys_ld), .en_i(ys_en),
        .nxt_o(ys_nxt), .last_o(ys_last)
    );
    ui_axis_sweep #(.LEN(H_N), .W(HL_W)) u_hl (
        .clk(clk), .resetn(resetn), .load_i(hl_ld), .en_i(hl_en),
        .nxt_o(hl_nxt), .last_o(hl_last)
    );
    ui_axis_sweep #(.LEN(V_N), .W(VL_W)) u_vl (
        .clk(clk), .resetn(resetn), .load_i(vl_ld), .en_i(vl_en),
        .nxt_o(vl_nxt), .last_o(vl_last)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        xs_ld = 1'b0; xs_en = 1'b0;
        ys_ld = 1'b0; ys_en = 1'b0;
        hl_ld = 1'b0; hl_en = 1'b0;
        vl_ld = 1'b0; vl_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                xs_ld = 1'b1; ys_ld = 1'b1;
                hl_ld = 1'b1; vl_ld = 1'b1;
                if (start) begin
                    state_d = FIRST;
                    col_d   = colour_in;
                end
            end
`ifdef UI_GRID_CLEAR_EN
            S_CLEAR: begin
                if (xs_last) begin
                    xs_ld = 1'b1;
                    if (ys_last) begin
                        ys_ld   = 1'b1;
                        state_d = AFTER_C;
                    end else begin
                        ys_en = 1'b1;
                    end
                end else begin
                    xs_en = 1'b1;
                end
            end
`endif
            S_HLINE: begin
                if (xs_last) begin
                    xs_ld = 1'b1;
                    if (hl_last) begin
                        hl_ld   = 1'b1;
                        state_d = AFTER_H;
                    end else begin
                        hl_en = 1'b1;
                    end
                end else begin
                    xs_en = 1'b1;
                end
            end
            S_VLINE: begin
                if (ys_last) begin
                    ys_ld = 1'b1;
                    if (vl_last) begin
                        vl_ld   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        vl_en = 1'b1;
                    end
                end else begin
                    ys_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state and counters being entered at this edge.
        plot_d = 1'b0;
        x_d    = '0;
        y_d    = '0;
        c_d    = COL_W'(BLACK);
        unique case (state_d)
`ifdef UI_GRID_CLEAR_EN
            S_CLEAR: begin
                plot_d = 1'b1;
                x_d    = xs_nxt;
                y_d    = ys_nxt;
            end
`endif
            S_HLINE: begin
                plot_d = 1'b1;
                x_d    = xs_nxt;
                y_d    = hrow[hl_nxt];
                c_d    = col_d;
            end
            S_VLINE: begin
                plot_d = 1'b1;
                x_d    = vcol[vl_nxt];
                y_d    = ys_nxt;
                c_d    = col_d;
            end
            default: ;
        endcase
        busy_d = plot_d;
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = c_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
